// File: rtl/axi_lite_bridge_pkg.sv
// Shared constants and beat-width helpers for the buffered AXI4-lite bridge.
// Each FIFO entry is a packed beat: AW/AR {addr}, W {data,strb}, B {resp}, R {data,resp}.
package axi_lite_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         B_BEAT_W    = 2;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int max5(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    function automatic int addr_beat_w(input int addr_width);
        return addr_width;
    endfunction

    function automatic int w_beat_w(input int data_width);
        return data_width + data_width / 8;
    endfunction

    function automatic int r_beat_w(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/axi_lite_chan_fifo.sv
// Single-clock valid/ready FIFO for one AXI-lite channel. Outputs depend only on
// registered state, so no combinational path crosses from one side to the other.
module axi_lite_chan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;
    logic             push;
    logic             pop;

    // Readiness is taken from the stored count only, so a full FIFO stays
    // not-ready during the cycle it is popped.
    assign s_ready = (occ_reg != OCC_W'(DEPTH));
    assign m_valid = (occ_reg != '0);
    assign m_data  = m_valid ? mem_reg[rd_ptr_reg] : '0;
    assign occ     = occ_reg;

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready;

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + OCC_W'(1);
            2'b01:   occ_next = occ_reg - OCC_W'(1);
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            occ_reg <= occ_next;
        end
    end

endmodule

// File: rtl/axi_lite_buffered_bridge.sv
// AXI4-lite buffer bridge: one FIFO per channel plus caps on in-flight writes
// and reads issued downstream, with live occupancy/outstanding debug outputs.
module axi_lite_buffered_bridge
    import axi_lite_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 6,
    parameter int DATA_WIDTH      = 8,
    parameter int AW_DEPTH        = 2,
    parameter int W_DEPTH         = 2,
    parameter int B_DEPTH         = 2,
    parameter int AR_DEPTH        = 2,
    parameter int R_DEPTH         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OCC_W           = occ_width(max5(AW_DEPTH, W_DEPTH, B_DEPTH, AR_DEPTH, R_DEPTH)),
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1),
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] S_AWADDR,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,
    input  logic [DATA_WIDTH-1:0] S_WDATA,
    input  logic [STRB_WIDTH-1:0] S_WSTRB,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    output logic [1:0]            S_BRESP,
    output logic                  S_BVALID,
    input  logic                  S_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_ARADDR,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,
    output logic [DATA_WIDTH-1:0] S_RDATA,
    output logic [1:0]            S_RRESP,
    output logic                  S_RVALID,
    input  logic                  S_RREADY,
    output logic [ADDR_WIDTH-1:0] M_AWADDR,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic [STRB_WIDTH-1:0] M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY,
    output logic [OUT_W-1:0]      WR_OUTSTANDING,
    output logic [OUT_W-1:0]      RD_OUTSTANDING,
    output logic [OCC_W-1:0]      AW_OCC,
    output logic [OCC_W-1:0]      W_OCC,
    output logic [OCC_W-1:0]      B_OCC,
    output logic [OCC_W-1:0]      AR_OCC,
    output logic [OCC_W-1:0]      R_OCC
);

    localparam int AW_BEAT_W = addr_beat_w(ADDR_WIDTH);
    localparam int W_BEAT_W  = w_beat_w(DATA_WIDTH);
    localparam int R_BEAT_W  = r_beat_w(DATA_WIDTH);

    logic                          aw_valid;
    logic                          ar_valid;
    logic                          wr_cap_ok;
    logic                          rd_cap_ok;
    logic                          aw_hs;
    logic                          b_hs;
    logic                          ar_hs;
    logic                          r_hs;
    logic [OUT_W-1:0]              wr_out_reg;
    logic [OUT_W-1:0]              rd_out_reg;
    logic [$clog2(AW_DEPTH+1)-1:0] aw_occ;
    logic [$clog2(W_DEPTH+1)-1:0]  w_occ;
    logic [$clog2(B_DEPTH+1)-1:0]  b_occ;
    logic [$clog2(AR_DEPTH+1)-1:0] ar_occ;
    logic [$clog2(R_DEPTH+1)-1:0]  r_occ;

    // Counts never go below zero; an unmatched response is flagged by the assertions below.
    function automatic logic [OUT_W-1:0] next_count(input logic [OUT_W-1:0] cur,
                                                    input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return cur + OUT_W'(1);
            2'b01:   return (cur == '0) ? cur : cur - OUT_W'(1);
            default: return cur;
        endcase
    endfunction

    assign wr_cap_ok = (wr_out_reg < OUT_W'(MAX_OUTSTANDING));
    assign rd_cap_ok = (rd_out_reg < OUT_W'(MAX_OUTSTANDING));
    assign M_AWVALID = aw_valid & wr_cap_ok;
    assign M_ARVALID = ar_valid & rd_cap_ok;
    assign aw_hs     = M_AWVALID & M_AWREADY;
    assign ar_hs     = M_ARVALID & M_ARREADY;
    assign b_hs      = M_BVALID & M_BREADY;
    assign r_hs      = M_RVALID & M_RREADY;

    axi_lite_chan_fifo #(.WIDTH(AW_BEAT_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk(ACLK), .srst(ARESET),
        .s_valid(S_AWVALID), .s_ready(S_AWREADY), .s_data(S_AWADDR),
        .m_valid(aw_valid), .m_ready(M_AWREADY & wr_cap_ok), .m_data(M_AWADDR),
        .occ(aw_occ)
    );

    axi_lite_chan_fifo #(.WIDTH(W_BEAT_W), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk(ACLK), .srst(ARESET),
        .s_valid(S_WVALID), .s_ready(S_WREADY), .s_data({S_WDATA, S_WSTRB}),
        .m_valid(M_WVALID), .m_ready(M_WREADY), .m_data({M_WDATA, M_WSTRB}),
        .occ(w_occ)
    );

    axi_lite_chan_fifo #(.WIDTH(B_BEAT_W), .DEPTH(B_DEPTH)) u_b_fifo (
        .clk(ACLK), .srst(ARESET),
        .s_valid(M_BVALID), .s_ready(M_BREADY), .s_data(M_BRESP),
        .m_valid(S_BVALID), .m_ready(S_BREADY), .m_data(S_BRESP),
        .occ(b_occ)
    );

    axi_lite_chan_fifo #(.WIDTH(AW_BEAT_W), .DEPTH(AR_DEPTH)) u_ar_fifo (
        .clk(ACLK), .srst(ARESET),
        .s_valid(S_ARVALID), .s_ready(S_ARREADY), .s_data(S_ARADDR),
        .m_valid(ar_valid), .m_ready(M_ARREADY & rd_cap_ok), .m_data(M_ARADDR),
        .occ(ar_occ)
    );

    axi_lite_chan_fifo #(.WIDTH(R_BEAT_W), .DEPTH(R_DEPTH)) u_r_fifo (
        .clk(ACLK), .srst(ARESET),
        .s_valid(M_RVALID), .s_ready(M_RREADY), .s_data({M_RDATA, M_RRESP}),
        .m_valid(S_RVALID), .m_ready(S_RREADY), .m_data({S_RDATA, S_RRESP}),
        .occ(r_occ)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_out_reg <= '0;
            rd_out_reg <= '0;
        end else begin
            wr_out_reg <= next_count(wr_out_reg, aw_hs, b_hs);
            rd_out_reg <= next_count(rd_out_reg, ar_hs, r_hs);
        end
    end

    assign WR_OUTSTANDING = wr_out_reg;
    assign RD_OUTSTANDING = rd_out_reg;
    assign AW_OCC         = OCC_W'(aw_occ);
    assign W_OCC          = OCC_W'(w_occ);
    assign B_OCC          = OCC_W'(b_occ);
    assign AR_OCC         = OCC_W'(ar_occ);
    assign R_OCC          = OCC_W'(r_occ);

    wr_underflow_a: assert property (@(posedge ACLK) disable iff (ARESET)
        !(b_hs && wr_out_reg == '0));
    rd_underflow_a: assert property (@(posedge ACLK) disable iff (ARESET)
        !(r_hs && rd_out_reg == '0));

endmodule

// File: doc/axi_lite_buffered_bridge.md
Name: axi_lite_buffered_bridge

Overview:
Parametrised AXI4-lite buffer bridge placed between the chip-IO AXI-lite master and any register-control slave in the fullchip AXI tree. It puts an independent synchronous FIFO on all five channels (AW, W, B, AR, R) with per-channel depth, and carries WSTRB, BRESP and RRESP. It also caps the number of outstanding write and read transactions and exports live occupancy and outstanding counts for debug readback.

Parameters:
ADDR_WIDTH, 6, AXI address width.
DATA_WIDTH, 8, AXI data width; multiple of 8; STRB_WIDTH = DATA_WIDTH/8.
AW_DEPTH / W_DEPTH / B_DEPTH / AR_DEPTH / R_DEPTH, 2, per-channel FIFO depth; power of 2, ≥2.
MAX_OUTSTANDING, 4, maximum in-flight writes, and separately maximum in-flight reads, on the M side; ≥1.
OCC_W, $clog2(max depth+1), width of the occupancy outputs.
OUT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding-count outputs.

Ports:
ACLK  in  1  single clock.
ARESET  in  1  synchronous, active-high reset.
S_AWADDR/S_AWVALID/S_AWREADY  in/in/out  ADDR_WIDTH/1/1  upstream write address.
S_WDATA/S_WSTRB/S_WVALID/S_WREADY  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  upstream write data.
S_BRESP/S_BVALID/S_BREADY  out/out/in  2/1/1  upstream write response.
S_ARADDR/S_ARVALID/S_ARREADY  in/in/out  ADDR_WIDTH/1/1  upstream read address.
S_RDATA/S_RRESP/S_RVALID/S_RREADY  out/out/out/in  DATA_WIDTH/2/1/1  upstream read data.
M_* (same set as S_*, directions mirrored)  —  —  downstream slave side.
WR_OUTSTANDING  out  OUT_W  writes issued on M_AW and not yet answered on M_B.
RD_OUTSTANDING  out  OUT_W  reads issued on M_AR and not yet answered on M_R.
AW_OCC/W_OCC/B_OCC/AR_OCC/R_OCC  out  OCC_W each  current entry count of each FIFO.

Behaviour:
- Reset: all FIFOs empty and pointers cleared. All *VALID outputs = 0, all *READY outputs = 1, counts = 0, data/resp outputs = 0. Reset mid-transaction discards every buffered beat without emitting any handshake.
- FIFO push: s_valid & s_ready. Pop: m_valid & m_ready. s_ready = (occ != DEPTH). m_valid = (occ != 0). m_data = head entry, driven from registers.
- Latency: a beat accepted at edge N is presented downstream after edge N, i.e. 1 cycle. There is no combinational valid→valid or ready→ready path.
- When full, s_ready = 0 even if a pop happens in the same cycle; ready reasserts the cycle after the pop. When not full, a simultaneous push and pop leaves occ unchanged.
- Pointers are modulo DEPTH and wrap naturally.
- Write channels: AW and W FIFOs are independent, so AW may lead or lag W by the full FIFO depth. {WDATA, WSTRB} are stored together.
- M_AWVALID = aw_fifo_valid & (WR_OUTSTANDING < MAX_OUTSTANDING). M_ARVALID follows the same rule with RD_OUTSTANDING.
- WR_OUTSTANDING: +1 on an M_AW handshake, −1 on an M_B handshake, unchanged if both occur in the same cycle. RD_OUTSTANDING does the same on M_AR / M_R.
- Underflow never occurs: the counts saturate at 0 and a debug assertion fires if an M_B or M_R handshake arrives with the count at 0.
- M_BREADY = B FIFO not full; M_RREADY = R FIFO not full.
- Response ordering equals issue order. There are no IDs.
- RRESP/BRESP pass through unmodified.

Decomposition:
- Package axi_lite_bridge_pkg holds: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, the clog2-based width functions, and the packed beat layouts ({addr}, {data,strb}, {resp}, {data,resp}).
- One natural sub-module, axi_lite_chan_fifo, parametrised by WIDTH and DEPTH with ports s_valid/s_ready/s_data, m_valid/m_ready/m_data and occ. It is instantiated five times.
- The top level holds only the outstanding counters and the AW/AR gating.

Test Plan:
- Reset released, single write: AW=0x05, W=0xA5, STRB=1; slave answers OKAY one cycle later. Expect M_AWVALID/M_WVALID 1 cycle after the S handshake, S_BVALID 1 cycle after M_B, BRESP=00, WR_OUTSTANDING 0→1→0.
- Backpressure: hold M_AWREADY=0 and push 3 AWs with depth 2. Expect S_AWREADY=0 after 2 accepted and AW_OCC=2. Release: entries exit in order 0x01, 0x02, then 0x03 is accepted.
- Outstanding cap, MAX_OUTSTANDING=4: the slave withholds RVALID while 6 reads are issued. Expect exactly 4 M_AR handshakes, RD_OUTSTANDING=4, M_ARVALID=0. Returning one R gives the 5th issue in the next cycle.
- Simultaneous events: M_B handshake and M_AW handshake in the same cycle with count=2. Expect the count to stay at 2. A full FIFO with a pop that cycle keeps s_ready=0 that cycle and gives 1 the next.
- Decoupled W before AW: send 2 W beats, then 2 AWs 5 cycles later. Expect correct pairing, W_OCC 2→0, and SLVERR from the slave propagated as S_BRESP=10.
- Reset mid-operation: assert ARESET with all FIFOs holding 1 entry and counts=1. Next cycle expect all OCC=0, counts=0, VALIDs=0, READYs=1, and no spurious S_B or S_R beat.
